// File: rtl/serdes_rx_decrypt.sv
// Serial receiver: collects MSB-first bits, XOR-decrypts each complete frame and queues the byte for a consumer.
// Build option SERDES_RX_FIFO_EN: FIFO_DEPTH-entry output FIFO; otherwise a single holding register.
module serdes_rx_decrypt #(
  parameter logic [7:0]  KEY        = 8'hA5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       sdi,
  input  logic       frame_done,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] frame_cnt,
  output logic       frame_err,
  output logic       overflow,
  input  logic       clr_err
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end

  logic [7:0] r_shreg;
  logic [3:0] r_cnt;

  logic       w_armed;
  logic       w_push;
  logic       w_short;
  logic       w_pop;
  logic       w_full;
  logic       w_accept;
  logic       w_drop;
  logic [7:0] w_byte;

  assign w_armed  = (r_cnt >= 4'd8);
  assign w_push   = en && frame_done && w_armed;
  assign w_short  = en && frame_done && !w_armed;
  assign w_pop    = out_valid && out_ready;
  assign w_accept = w_push && (!w_full || w_pop);
  assign w_drop   = w_push && w_full && !w_pop;
  assign w_byte   = r_shreg ^ KEY;

  // Line sampling: held clear while disabled, cleared at every frame boundary.
  always_ff @(posedge clk) begin
    if (rst || !en || frame_done) begin
      r_shreg <= 8'h00;
      r_cnt   <= 4'd0;
    end else begin
      r_shreg <= {r_shreg[6:0], sdi};
      if (r_cnt != 4'd15) r_cnt <= r_cnt + 4'd1;
    end
  end

  // Status: set events take priority over clr_err.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 8'h00;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (w_accept) frame_cnt <= frame_cnt + 8'd1;
      if (w_short)      frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (w_drop)       overflow  <= 1'b1;
      else if (clr_err) overflow  <= 1'b0;
    end
  end

`ifdef SERDES_RX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [LW-1:0] r_level;

  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign out_valid = (r_level != '0);
  assign out_data  = r_mem[r_rd];

  // When full, a same-cycle pop frees the slot the write pointer already addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_level <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= 8'h00;
    end else begin
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_accept) begin
        r_mem[r_wr] <= w_byte;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_accept && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_accept && w_pop) r_level <= r_level - LW'(1);
    end
  end
`else
  logic [7:0] r_data;
  logic       r_valid;

  assign w_full    = r_valid;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_data  <= w_byte;
      r_valid <= 1'b1;
    end else if (w_pop) begin
      r_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_serdes_rx_decrypt.sv
// Bench for serdes_rx_decrypt: vector table, directed corner sequences and random traffic against a queue model.
module tb_serdes_rx_decrypt;

  localparam logic [7:0] KEY = 8'hA5;
`ifdef SERDES_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sdi = 1'b0;
  logic       frame_done = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [7:0] frame_cnt;
  logic       frame_err;
  logic       overflow;

  serdes_rx_decrypt #(.KEY(KEY), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .sdi(sdi), .frame_done(frame_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_cnt(frame_cnt), .frame_err(frame_err), .overflow(overflow),
    .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: bits seen since the last boundary, plus a byte queue.
  int         m_bits;
  logic [7:0] m_sh;
  logic [7:0] q[$];
  logic [7:0] m_fc;
  bit         m_err;
  bit         m_ovf;

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  function automatic void model_tick(input bit r, input bit e, input bit s, input bit fd,
                                     input bit rdy, input bit clr);
    bit pop, push, bad;
    if (r) begin
      m_bits = 0; m_sh = 8'h00; q.delete(); m_fc = 8'h00; m_err = 0; m_ovf = 0;
      return;
    end
    pop  = (q.size() > 0) && rdy;
    push = e && fd && (m_bits >= 8);
    bad  = e && fd && (m_bits < 8);
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) begin
        q.push_back(m_sh ^ KEY);
        m_fc = m_fc + 8'd1;
      end else begin
        m_ovf = 1;
      end
    end else if (clr) begin
      m_ovf = 0;
    end
    if (bad) m_err = 1;
    else if (clr) m_err = 0;
    if (!e || fd) begin
      m_bits = 0; m_sh = 8'h00;
    end else begin
      m_sh = {m_sh[6:0], s};
      m_bits = (m_bits >= 15) ? 15 : m_bits + 1;
    end
  endfunction

  function automatic void check_model();
    chk("valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
    chk("frame_cnt", int'(frame_cnt), int'(m_fc));
    chk("frame_err", int'(frame_err), int'(m_err));
    chk("overflow", int'(overflow), int'(m_ovf));
    if (q.size() > 0) chk("data", int'(out_data), int'(q[0]));
  endfunction

  task automatic step(input bit r, input bit e, input bit s, input bit fd,
                      input bit rdy, input bit clr);
    rst = r; en = e; sdi = s; frame_done = fd; out_ready = rdy; clr_err = clr;
    @(posedge clk);
    model_tick(r, e, s, fd, rdy, clr);
    @(negedge clk);
    check_model();
  endtask

  task automatic send_bits(input logic [15:0] pat, input int n, input bit rdy);
    for (int i = n - 1; i >= 0; i--) step(0, 1, pat[i], 0, rdy, 0);
  endtask

  task automatic send_frame(input logic [7:0] enc, input bit rdy_on_done);
    send_bits({8'h00, enc}, 8, 0);
    step(0, 1, 0, 1, rdy_on_done, 0);
  endtask

  typedef struct {
    logic [15:0] pat;
    int          nbits;
    bit          vld;
    logic [7:0]  data;
    bit          err;
  } vec_t;

  vec_t tv[8];

  initial begin
    tv[0] = '{16'h0099, 8,  1'b1, 8'h3C, 1'b0};
    tv[1] = '{16'h00A5, 8,  1'b1, 8'h00, 1'b0};
    tv[2] = '{16'h005A, 8,  1'b1, 8'hFF, 1'b0};
    tv[3] = '{16'h0399, 10, 1'b1, 8'h3C, 1'b0};
    tv[4] = '{16'hFF12, 16, 1'b1, 8'hB7, 1'b0};
    tv[5] = '{16'h0005, 3,  1'b0, 8'h00, 1'b1};
    tv[6] = '{16'h007F, 7,  1'b0, 8'h00, 1'b1};
    tv[7] = '{16'h0000, 0,  1'b0, 8'h00, 1'b1};

    model_tick(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_fc", int'(frame_cnt), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_ovf", int'(overflow), 0);

    // Vector table: one frame each, checked the cycle after frame_done, then drained and cleared.
    for (int k = 0; k < 8; k++) begin
      send_bits(tv[k].pat, tv[k].nbits, 0);
      step(0, 1, 0, 1, 0, 0);
      chk("tv_valid", int'(out_valid), int'(tv[k].vld));
      if (tv[k].vld) chk("tv_data", int'(out_data), int'(tv[k].data));
      chk("tv_err", int'(frame_err), int'(tv[k].err));
      step(0, 0, 0, 0, 1, 1);
      chk("tv_clr", int'(frame_err), 0);
      chk("tv_empty", int'(out_valid), 0);
    end
    chk("tv_fc", int'(frame_cnt), 5);

    // Overflow with consumer stalled: frames encrypting 01..05.
    step(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) send_frame(8'(k) ^ KEY, 0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_fc", int'(frame_cnt), DEPTH);
    for (int k = 1; k <= DEPTH; k++) begin
      chk("ovf_drain", int'(out_data), k);
      chk("ovf_drain_v", int'(out_valid), 1);
      step(0, 0, 0, 0, 1, 0);
    end
    chk("ovf_empty", int'(out_valid), 0);

    // Full output with a pop on the frame_done cycle: no drop, new byte queued last.
    step(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= DEPTH; k++) send_frame(8'(8'h10 + k) ^ KEY, 0);
    send_frame(8'h77 ^ KEY, 1);
    chk("fullpop_ovf", int'(overflow), 0);
    chk("fullpop_fc", int'(frame_cnt), DEPTH + 1);
    for (int k = 2; k <= DEPTH; k++) begin
      chk("fullpop_order", int'(out_data), 8'h10 + k);
      step(0, 0, 0, 0, 1, 0);
    end
    chk("fullpop_last", int'(out_data), 8'h77);
    step(0, 0, 0, 0, 1, 0);
    chk("fullpop_empty", int'(out_valid), 0);

    // Reset mid-frame discards the partial frame.
    step(1, 0, 0, 0, 0, 0);
    send_bits(16'h001F, 5, 0);
    step(1, 1, 1, 0, 0, 0);
    send_bits(16'h0099, 8, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("rstmid_fc", int'(frame_cnt), 1);
    chk("rstmid_data", int'(out_data), 8'h3C);
    chk("rstmid_err", int'(frame_err), 0);

    // en dropped mid-frame: partial discarded, later frame_done is an error.
    step(1, 0, 0, 0, 0, 0);
    send_bits(16'h000F, 4, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    send_bits(16'h000F, 4, 0);
    step(0, 1, 0, 1, 0, 0);
    chk("endrop_err", int'(frame_err), 1);
    chk("endrop_valid", int'(out_valid), 0);
    chk("endrop_fc", int'(frame_cnt), 0);

    // Set event in the same cycle as clr_err wins.
    step(0, 0, 0, 0, 0, 1);
    chk("clr_only", int'(frame_err), 0);
    step(0, 1, 0, 1, 0, 1);
    chk("set_wins", int'(frame_err), 1);

    // frame_cnt wraps 255 -> 0.
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 260; k++) begin
      send_bits({8'h00, 8'(k)}, 8, 1);
      step(0, 1, 0, 1, 1, 0);
    end
    chk("wrap_fc", int'(frame_cnt), 4);

    // Random traffic against the model.
    step(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4000; c++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, 1'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serdes_rx_decrypt.md
SERDES_RX_DECRYPT -- requirements
Module: serdes_rx_decrypt

Interface
REQ-001 Parameter KEY, default 8'hA5, XOR decryption key; must match the transmitter key.
REQ-002 Parameter FIFO_DEPTH, default 4, output FIFO entries; power of two, 2..16; used only when SERDES_RX_FIFO_EN is defined.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  receive enable; low = line ignored.
REQ-006 sdi  input  1  serial data, MSB-first, one bit per clk.
REQ-007 frame_done  input  1  one-cycle pulse marking end of frame; asserted the cycle after the last data bit.
REQ-008 out_data  output  8  decrypted byte at FIFO head.
REQ-009 out_valid  output  1  out_data holds a valid byte.
REQ-010 out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
REQ-011 frame_cnt  output  8  count of frames pushed to output; wraps 255 -> 0.
REQ-012 frame_err  output  1  sticky; frame_done seen with fewer than 8 samples.
REQ-013 overflow  output  1  sticky; decoded frame dropped because output full.
REQ-014 clr_err  input  1  clears frame_err and overflow.

Function
REQ-015 States: OFF (en=0), HUNT (en=1, sample count < 8), ARMED (en=1, count >= 8).
REQ-016 In OFF: shift register and sample count held at 0; frame_done ignored; buffered output bytes remain drainable.
REQ-017 While en=1 and frame_done=0: shreg <= {shreg[6:0], sdi}; sample count increments, saturating at 15.
REQ-018 On a frame_done cycle: sdi is not sampled; shreg and count clear to 0; next state HUNT.
REQ-019 frame_done in ARMED: byte = shreg ^ KEY pushed to output; frame_cnt increments.
REQ-020 frame_done in HUNT: nothing pushed; frame_err sets; frame_cnt unchanged.
REQ-021 Latency: pushed byte appears on out_data with out_valid=1 on the cycle after frame_done when output was empty.
REQ-022 Pop occurs on any cycle with out_valid && out_ready; the next entry appears on the following cycle.
REQ-023 Push while full with no pop in the same cycle: byte dropped; overflow sets; frame_cnt unchanged.
REQ-024 Push while full with a pop in the same cycle: push accepted; occupancy unchanged.
REQ-025 Push and pop on a non-empty, non-full output: occupancy unchanged; ordering FIFO.
REQ-026 Sticky flags: clr_err clears both; a set event in the same cycle as clr_err wins.
REQ-027 en deasserted mid-frame: partial frame discarded; a frame_done arriving later in HUNT sets frame_err.
REQ-028 out_data shall hold its value while out_valid=1 and out_ready=0.

Reset
REQ-029 rst=1 on a clk edge: state OFF/HUNT per en, shreg=0, count=0, output storage empty.
REQ-030 Reset values: out_valid=0, out_data=8'h00, frame_cnt=0, frame_err=0, overflow=0.
REQ-031 rst overrides all inputs; reset mid-frame discards the partial frame and all buffered bytes.

Configuration
REQ-032 Macro SERDES_RX_FIFO_EN defined: output storage is a FIFO_DEPTH-entry FIFO; full = FIFO_DEPTH entries.
REQ-033 Macro SERDES_RX_FIFO_EN undefined: output storage is a single holding register; full = out_valid=1; REQ-021..028 apply unchanged.

Verification
REQ-034 en=1, sdi=1,0,0,1,1,0,0,1 then frame_done -> next cycle out_data=8'h3C, out_valid=1, frame_cnt=1.
REQ-035 en=1, 3 sdi samples then frame_done -> no push, frame_err=1, frame_cnt=0; clr_err -> frame_err=0.
REQ-036 out_ready=0; FIFO build: 5 frames encrypting 8'h01..8'h05 -> overflow=1, frame_cnt=4; draining yields 01,02,03,04 in order. Single-register build: after frame 2 -> overflow=1, frame_cnt=1, out_data=8'h01.
REQ-037 Output full, out_ready=1 on the frame_done cycle -> no overflow; new byte queued behind remaining entries.
REQ-038 rst pulsed after 5 bits of a frame, then a full 8-bit frame sent -> only the second frame is decoded, frame_cnt=1.
REQ-039 en dropped for 2 cycles mid-frame, then frame_done -> frame_err=1, no output byte.
